// File: rtl/mio_bus_arbiter_pkg.sv
// Shared constants for the two-master memory/IO arbiter: FSM state encoding,
// owner identifiers and the tie-break helper.
package mio_arb_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS = 2'd1;
  localparam logic [1:0] ARB_RESP   = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // Picks the master to serve from the current requests. With rr set, a tie
  // goes to whichever master was not served last; otherwise the CPU wins.
  function automatic logic pick_owner(input logic cpu_req,
                                      input logic dma_req,
                                      input logic last_owner,
                                      input logic rr);
    logic owner;
    if (cpu_req && dma_req) begin
      if (rr)
        owner = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
      else
        owner = OWN_CPU;
    end else if (cpu_req) begin
      owner = OWN_CPU;
    end else begin
      owner = OWN_DMA;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mio_bus_arbiter_if.sv
// Handshake bundle between the CPU/DMA masters, the arbiter and the memory/IO
// bus. The arbiter uses the slave modport; requesters and the bus model use master.
interface mio_bus_arbiter_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic        dma_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_err,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack, dma_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_err,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack, dma_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  busy
  );

endinterface

// File: rtl/mio_bus_arbiter_timer.sv
// ACCESS-phase timeout counter for the arbiter. Counts enabled cycles from a
// clear and flags the last permitted wait cycle.
module mio_arb_timer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TW      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable)
      cnt <= cnt + TW'(1);
  end

  assign expired = (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mio_bus_arbiter.sv
// Two-master arbiter for the CPU data-memory/IO port: one transaction at a time
// through IDLE/ACCESS/RESP with a bus timeout. Define MIO_ARB_RR_EN for
// round-robin tie-break; default build gives the CPU fixed priority.
module mio_bus_arbiter
  import mio_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TW      = 5
) (
  input logic               clk,
  input logic               rst,
  mio_bus_arbiter_if.slave  bus
);

  logic [1:0]  state;
  logic        owner;
  logic        win;
  logic        any_req;
  logic        expired;
  logic        done;
  logic        load_rdata;
  logic [31:0] rdata_next;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] cpu_rdata_q;
  logic [31:0] dma_rdata_q;
  logic        cpu_ack_q;
  logic        dma_ack_q;
  logic        cpu_err_q;
  logic        dma_err_q;

  mio_arb_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ARB_ACCESS),
    .enable  (state == ARB_ACCESS),
    .expired (expired)
  );

  // owner holds the master of the current transaction; with round-robin it
  // doubles as the last-served record, reset to DMA so the CPU wins first.
  always_comb begin
    any_req = bus.cpu_req | bus.dma_req;
`ifdef MIO_ARB_RR_EN
    win = pick_owner(bus.cpu_req, bus.dma_req, owner, 1'b1);
`else
    win = pick_owner(bus.cpu_req, bus.dma_req, owner, 1'b0);
`endif
  end

  // mem_ready takes precedence over a coincident timeout.
  always_comb begin
    done       = bus.mem_ready | expired;
    load_rdata = ~bus.mem_ready | ~mem_we_q;
    rdata_next = bus.mem_ready ? bus.mem_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      owner       <= OWN_DMA;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      dma_err_q   <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      cpu_err_q <= 1'b0;
      dma_err_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            owner     <= win;
            mem_req_q <= 1'b1;
            if (win == OWN_CPU) begin
              mem_we_q    <= bus.cpu_we;
              mem_addr_q  <= bus.cpu_addr;
              mem_wdata_q <= bus.cpu_wdata;
            end else begin
              mem_we_q    <= bus.dma_we;
              mem_addr_q  <= bus.dma_addr;
              mem_wdata_q <= bus.dma_wdata;
            end
            state <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (done) begin
            mem_req_q <= 1'b0;
            state     <= ARB_RESP;
            // ack/err register here so they are high for the whole RESP cycle
            if (owner == OWN_CPU) begin
              cpu_ack_q <= 1'b1;
              cpu_err_q <= ~bus.mem_ready;
              if (load_rdata)
                cpu_rdata_q <= rdata_next;
            end else begin
              dma_ack_q <= 1'b1;
              dma_err_q <= ~bus.mem_ready;
              if (load_rdata)
                dma_rdata_q <= rdata_next;
            end
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.cpu_err   = cpu_err_q;
  assign bus.dma_err   = dma_err_q;
  assign bus.busy      = (state != ARB_IDLE);

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Self-checking bench for mio_bus_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_mio_bus_arbiter;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mio_bus_arbiter_if bus ();

  mio_bus_arbiter #(
    .TIMEOUT (TO),
    .TW      (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: per-master expected rdata and last-served master.
  logic [31:0] exp_rdata [2];
  int          last_served;

  // Request descriptors per master (0 = CPU, 1 = DMA).
  logic        d_we    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_ack(input int m);
    return 32'(m == 0 ? bus.cpu_ack : bus.dma_ack);
  endfunction

  function automatic logic [31:0] get_err(input int m);
    return 32'(m == 0 ? bus.cpu_err : bus.dma_err);
  endfunction

  task automatic set_desc(input int m, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    d_we[m] = we; d_addr[m] = addr; d_wdata[m] = wdata;
  endtask

  task automatic drive_req(input int m, input logic on);
    if (m == 0) begin
      bus.cpu_req = on; bus.cpu_we = d_we[0];
      bus.cpu_addr = d_addr[0]; bus.cpu_wdata = d_wdata[0];
    end else begin
      bus.dma_req = on; bus.dma_we = d_we[1];
      bus.dma_addr = d_addr[1]; bus.dma_wdata = d_wdata[1];
    end
  endtask

  // Arbitration rule as stated: single requester wins; ties go to CPU, or to
  // the master not served last when round-robin is built in.
  function automatic int model_winner(input logic c, input logic d);
    if (c && d) begin
`ifdef MIO_ARB_RR_EN
      return (last_served == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return c ? 0 : 1;
  endfunction

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_mem_req"},   32'(bus.mem_req), 32'd0);
    check({pfx, "_mem_we"},    32'(bus.mem_we), 32'd0);
    check({pfx, "_mem_addr"},  bus.mem_addr, 32'd0);
    check({pfx, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({pfx, "_busy"},      32'(bus.busy), 32'd0);
    check({pfx, "_cpu_ack"},   32'(bus.cpu_ack), 32'd0);
    check({pfx, "_dma_ack"},   32'(bus.dma_ack), 32'd0);
    check({pfx, "_cpu_err"},   32'(bus.cpu_err), 32'd0);
    check({pfx, "_dma_err"},   32'(bus.dma_err), 32'd0);
    check({pfx, "_cpu_rdata"}, bus.cpu_rdata, 32'd0);
    check({pfx, "_dma_rdata"}, bus.dma_rdata, 32'd0);
  endtask

  // One transaction, entered at a negedge with the arbiter idle. The bus
  // answers on ACCESS cycle waits+1 unless the timeout comes first.
  task automatic run_txn(input logic raise_c, input logic raise_d, input int waits,
                         input logic [31:0] rd_val);
    int w;
    int done_at;
    logic tout;
    if (raise_c) drive_req(0, 1'b1);
    if (raise_d) drive_req(1, 1'b1);
    w       = model_winner(bus.cpu_req, bus.dma_req);
    tout    = (waits + 1 > int'(TO));
    done_at = tout ? int'(TO) : waits + 1;
    @(posedge clk);
    for (int k = 1; k <= done_at; k++) begin
      @(negedge clk);
      check("acc_mem_req",   32'(bus.mem_req), 32'd1);
      check("acc_mem_we",    32'(bus.mem_we), 32'(d_we[w]));
      check("acc_mem_addr",  bus.mem_addr, d_addr[w]);
      check("acc_mem_wdata", bus.mem_wdata, d_wdata[w]);
      check("acc_busy",      32'(bus.busy), 32'd1);
      check("acc_cpu_ack",   32'(bus.cpu_ack), 32'd0);
      check("acc_dma_ack",   32'(bus.dma_ack), 32'd0);
      bus.mem_ready = (k == waits + 1);
      bus.mem_rdata = (k == waits + 1) ? rd_val : $urandom();
      @(posedge clk);
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    last_served = w;
    if (tout) exp_rdata[w] = '0;
    else if (!d_we[w]) exp_rdata[w] = rd_val;
    check("resp_ack",       get_ack(w), 32'd1);
    check("resp_other_ack", get_ack(1 - w), 32'd0);
    check("resp_err",       get_err(w), 32'(tout));
    check("resp_cpu_rdata", bus.cpu_rdata, exp_rdata[0]);
    check("resp_dma_rdata", bus.dma_rdata, exp_rdata[1]);
    check("resp_mem_req",   32'(bus.mem_req), 32'd0);
    check("resp_busy",      32'(bus.busy), 32'd1);
    drive_req(w, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("idle_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    check("idle_dma_ack", 32'(bus.dma_ack), 32'd0);
    check("idle_busy",    32'(bus.busy), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2; i++)
      if (bus.cpu_req || bus.dma_req) run_txn(1'b0, 1'b0, 0, $urandom());
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    for (int m = 0; m < 2; m++) begin
      set_desc(m, 1'b0, '0, '0);
      drive_req(m, 1'b0);
      exp_rdata[m] = '0;
    end
    last_served = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // CPU read, ready on the first ACCESS cycle.
    set_desc(0, 1'b0, 32'h0000_0040, 32'h0);
    run_txn(1'b1, 1'b0, 0, 32'hDEAD_BEEF);

    // DMA write with three wait states.
    set_desc(1, 1'b1, 32'h0000_0100, 32'h1234_5678);
    run_txn(1'b0, 1'b1, 3, $urandom());

    // Timeout, then a normal read.
    set_desc(0, 1'b0, 32'h0000_0200, 32'h0);
    run_txn(1'b1, 1'b0, 100, $urandom());
    set_desc(0, 1'b0, 32'h0000_0204, 32'h0);
    run_txn(1'b1, 1'b0, 1, 32'hA5A5_5A5A);

    // Both masters requesting for four transactions.
    set_desc(0, 1'b0, 32'h0000_0300, 32'h0);
    set_desc(1, 1'b1, 32'h0000_0400, 32'h0BAD_F00D);
    for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b1, 0, $urandom());
    drain();

    // Ready coincides with the last permitted wait cycle; then one cycle late.
    set_desc(0, 1'b0, 32'h0000_0500, 32'h0);
    run_txn(1'b1, 1'b0, int'(TO) - 1, 32'hCAFE_F00D);
    set_desc(1, 1'b0, 32'h0000_0600, 32'h0);
    run_txn(1'b0, 1'b1, int'(TO), $urandom());

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      logic rc;
      logic rd;
      int   waits;
      for (int m = 0; m < 2; m++) begin
        if (!(m == 0 ? bus.cpu_req : bus.dma_req))
          set_desc(m, 1'($urandom_range(0, 1)), $urandom(), $urandom());
      end
      rc = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!rc && !rd && !bus.cpu_req && !bus.dma_req) rc = 1'b1;
      if ($urandom_range(0, 3) == 0) waits = int'($urandom_range(TO - 2, TO + 3));
      else waits = int'($urandom_range(0, 4));
      run_txn(rc, rd, waits, $urandom());
    end
    drain();

    // Reset in the middle of an ACCESS phase.
    set_desc(0, 1'b0, 32'h0000_0700, 32'h0);
    drive_req(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    drive_req(0, 1'b0);
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_served  = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
      check("postrst_mem_req", 32'(bus.mem_req), 32'd0);
    end
    set_desc(0, 1'b0, 32'h0000_0704, 32'h0);
    run_txn(1'b1, 1'b0, 2, 32'h600D_CAFE);
    set_desc(0, 1'b0, 32'h0000_0800, 32'h0);
    set_desc(1, 1'b0, 32'h0000_0900, 32'h0);
    run_txn(1'b1, 1'b1, 0, $urandom());
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
